// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier (radix-2 or radix-4) with start/busy/done handshake.
module booth_mult_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          RADIX4 = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // Bits retired per step; the accumulator carries STEP guard bits so +-M / +-2M never overflow.
  localparam int unsigned STEP   = RADIX4 ? 2 : 1;
  localparam int unsigned AW     = WIDTH + STEP;
  localparam int unsigned NSTEPS = WIDTH / STEP;
  localparam int unsigned CW     = $clog2(NSTEPS) + 1;
  localparam int unsigned TW     = AW + WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [AW-1:0]        a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [AW-1:0]        m_ext;
  logic [AW-1:0]        m2_ext;
  logic [AW-1:0]        addend;
  logic [AW-1:0]        sum;
  logic [TW-1:0]        shifted;

  // Booth recoding of the low multiplier bits, add, and arithmetic shift of {A,Q,q_m1}.
  always_comb begin
    m_ext  = {{STEP{m_q[WIDTH-1]}}, m_q};
    m2_ext = {m_ext[AW-2:0], 1'b0};
    addend = '0;
    if (RADIX4) begin
      case ({q_q[1], q_q[0], qm1_q})
        3'b001, 3'b010: addend = m_ext;
        3'b011:         addend = m2_ext;
        3'b100:         addend = -m2_ext;
        3'b101, 3'b110: addend = -m_ext;
        default:        addend = '0;
      endcase
    end else begin
      case ({q_q[0], qm1_q})
        2'b01:   addend = m_ext;
        2'b10:   addend = -m_ext;
        default: addend = '0;
      endcase
    end
    sum     = a_q + addend;
    shifted = TW'($signed({sum, q_q, qm1_q}) >>> STEP);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = shifted[TW-1 -: AW];
        q_d   = shifted[WIDTH:1];
        qm1_d = shifted[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NSTEPS - 1)) begin
          state_d   = DONE;
          product_d = {a_d[WIDTH-1:0], q_d};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset overrides any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: four configurations (W8/W4 x radix-2/radix-4).
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cyc = 32'd0;

  logic [7:0]  m8, q8;
  logic [3:0]  m4, q4;
  logic        s8r2, s8r4, s4r2, s4r4;
  logic        b8r2, b8r4, b4r2, b4r4;
  logic        d8r2, d8r4, d4r2, d4r4;
  logic [15:0] p8r2, p8r4;
  logic [7:0]  p4r2, p4r4;

  typedef struct packed {
    logic [15:0] p;
    logic [31:0] c;
  } exp_t;

  exp_t q_8r2[$];
  exp_t q_8r4[$];
  exp_t q_4r2[$];
  exp_t q_4r4[$];

  int n_cmp = 0;
  int n_err = 0;
  int dn_4r2 = 0;
  int dn_4r4 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  booth_mult_seq #(.WIDTH(8), .RADIX4(1'b0)) u8r2 (
    .clk(clk), .rst(rst), .start(s8r2), .multiplicand(m8), .multiplier(q8),
    .busy(b8r2), .done(d8r2), .product(p8r2));
  booth_mult_seq #(.WIDTH(8), .RADIX4(1'b1)) u8r4 (
    .clk(clk), .rst(rst), .start(s8r4), .multiplicand(m8), .multiplier(q8),
    .busy(b8r4), .done(d8r4), .product(p8r4));
  booth_mult_seq #(.WIDTH(4), .RADIX4(1'b0)) u4r2 (
    .clk(clk), .rst(rst), .start(s4r2), .multiplicand(m4), .multiplier(q4),
    .busy(b4r2), .done(d4r2), .product(p4r2));
  booth_mult_seq #(.WIDTH(4), .RADIX4(1'b1)) u4r4 (
    .clk(clk), .rst(rst), .start(s4r4), .multiplicand(m4), .multiplier(q4),
    .busy(b4r4), .done(d4r4), .product(p4r4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Done cycle: the negedge sample after accept edge k plus N steps sees done high.
  task automatic issue8(input bit r4, input logic [7:0] mv, input logic [7:0] qv,
                        input logic [15:0] pv, input bit push);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!(r4 ? b8r4 : b8r2)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag_fail("issue8 idle timeout");
    m8 = mv;
    q8 = qv;
    if (r4) s8r4 = 1'b1; else s8r2 = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.p = pv;
      e.c = cyc + (r4 ? 32'd4 : 32'd8);
      if (r4) q_8r4.push_back(e); else q_8r2.push_back(e);
    end
    @(negedge clk);
    s8r2 = 1'b0;
    s8r4 = 1'b0;
  endtask

  task automatic issue4(input bit r4, input logic [3:0] mv, input logic [3:0] qv,
                        input logic [7:0] pv);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!(r4 ? b4r4 : b4r2)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag_fail("issue4 idle timeout");
    m4 = mv;
    q4 = qv;
    if (r4) s4r4 = 1'b1; else s4r2 = 1'b1;
    @(posedge clk);
    #1;
    e.p = {8'h00, pv};
    e.c = cyc + (r4 ? 32'd2 : 32'd4);
    if (r4) q_4r4.push_back(e); else q_4r2.push_back(e);
    @(negedge clk);
    s4r2 = 1'b0;
    s4r4 = 1'b0;
  endtask

  initial begin
    exp_t        e;
    int          nb;
    logic [31:0] k;

    rst  = 1'b1;
    s8r2 = 1'b0; s8r4 = 1'b0; s4r2 = 1'b0; s4r4 = 1'b0;
    m8 = '0; q8 = '0; m4 = '0; q4 = '0;
    repeat (3) @(negedge clk);
    check("reset product 8r2", p8r2, 0);
    check("reset busy 8r2", b8r2, 0);
    check("reset done 8r2", d8r2, 0);
    check("reset product 8r4", p8r4, 0);
    check("reset busy 4r2", b4r2, 0);
    // Start asserted together with reset must be dropped.
    s8r2 = 1'b1;
    m8 = 8'h11;
    q8 = 8'h22;
    @(negedge clk);
    check("reset beats start busy", b8r2, 0);
    s8r2 = 1'b0;
    rst  = 1'b0;

    // Monitor: every done pulse pops one expectation and checks product and arrival cycle.
    fork
      forever begin
        @(negedge clk);
        if (d8r2) begin
          if (q_8r2.size() == 0) flag_fail("u8r2 unexpected done");
          else begin
            e = q_8r2.pop_front();
            check("u8r2 product", p8r2, e.p);
            check("u8r2 done cycle", cyc, e.c);
          end
        end
        if (d8r4) begin
          if (q_8r4.size() == 0) flag_fail("u8r4 unexpected done");
          else begin
            e = q_8r4.pop_front();
            check("u8r4 product", p8r4, e.p);
            check("u8r4 done cycle", cyc, e.c);
          end
        end
        if (d4r2) begin
          dn_4r2++;
          if (q_4r2.size() == 0) flag_fail("u4r2 unexpected done");
          else begin
            e = q_4r2.pop_front();
            check("u4r2 product", p4r2, e.p);
            check("u4r2 done cycle", cyc, e.c);
          end
        end
        if (d4r4) begin
          dn_4r4++;
          if (q_4r4.size() == 0) flag_fail("u4r4 unexpected done");
          else begin
            e = q_4r4.pop_front();
            check("u4r4 product", p4r4, e.p);
            check("u4r4 done cycle", cyc, e.c);
          end
        end
      end
    join_none

    // Radix-2 directed: 7*-3, busy spans 8 RUN cycles plus DONE.
    issue8(1'b0, 8'h07, 8'hFD, 16'hFFEB, 1'b1);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (!b8r2) break;
      nb++;
      @(negedge clk);
    end
    check("u8r2 busy cycles", nb, 9);
    issue8(1'b0, 8'h80, 8'h80, 16'h4000, 1'b1);
    issue8(1'b0, 8'h80, 8'h7F, 16'hC080, 1'b1);
    issue8(1'b0, 8'h7F, 8'h7F, 16'h3F01, 1'b1);
    issue8(1'b0, 8'hFF, 8'hFF, 16'h0001, 1'b1);
    issue8(1'b0, 8'h00, 8'h5A, 16'h0000, 1'b1);

    // Radix-4 directed.
    issue8(1'b1, 8'h64, 8'hC7, 16'hE9BC, 1'b1);
    issue8(1'b1, 8'h80, 8'h80, 16'h4000, 1'b1);
    issue8(1'b1, 8'h7F, 8'h80, 16'hC080, 1'b1);
    issue8(1'b1, 8'hFF, 8'h01, 16'hFFFF, 1'b1);
    issue8(1'b1, 8'h55, 8'hAA, 16'hE372, 1'b1);

    // Start held high with operands changing: -5*9 then 3*11 accepted 10 edges later.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!b8r2) break;
    end
    m8 = 8'hFB;
    q8 = 8'h09;
    s8r2 = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    e.p = 16'hFFD3; e.c = k + 32'd8;  q_8r2.push_back(e);
    e.p = 16'h0021; e.c = k + 32'd18; q_8r2.push_back(e);
    @(negedge clk);
    m8 = 8'h03;
    q8 = 8'h0B;
    for (int i = 0; i < 50; i++) begin
      if (cyc >= k + 32'd10) break;
      @(negedge clk);
    end
    s8r2 = 1'b0;

    // Reset during RUN: outputs clear and no done pulse follows.
    issue8(1'b0, 8'h05, 8'h03, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-run reset busy", b8r2, 0);
    check("mid-run reset done", d8r2, 0);
    check("mid-run reset product", p8r2, 0);
    repeat (12) @(negedge clk);

    // Exhaustive 4-bit sweeps against the signed reference product.
    for (int a = -8; a < 8; a++)
      for (int b = -8; b < 8; b++)
        issue4(1'b0, 4'(a), 4'(b), 8'(a * b));
    for (int a = -8; a < 8; a++)
      for (int b = -8; b < 8; b++)
        issue4(1'b1, 4'(a), 4'(b), 8'(a * b));

    for (int i = 0; i < 200; i++) begin
      if (q_8r2.size() == 0 && q_8r4.size() == 0 && q_4r2.size() == 0 && q_4r4.size() == 0)
        break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("u8r2 pending", q_8r2.size(), 0);
    check("u8r4 pending", q_8r4.size(), 0);
    check("u4r2 pending", q_4r2.size(), 0);
    check("u4r4 pending", q_4r4.size(), 0);
    check("u4r2 done count", dn_4r2, 256);
    check("u4r4 done count", dn_4r4, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
